// File: rtl/sample_fifo_mc.sv
// Multi-channel sample FIFO: each entry holds a channel tag plus a sample.
// Registered occupancy/status flags, one-cycle read latency, sticky over/underrun flags.
module sample_fifo_mc #(
  parameter int DATA_WIDTH = 20,
  parameter int NUM_CH     = 3,
  parameter int DEPTH      = 96,
  parameter int OVR_MODE   = 0,
  localparam int CH_W      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  mems_clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [CH_W-1:0]       wr_ch,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CH_W-1:0]       rd_ch,
  output logic [CNT_W-1:0]      entries,
  input  logic [CNT_W-1:0]      wm_level,
  output logic                  wm_hit,
  output logic                  empty,
  output logic                  full,
  output logic                  ovr,
  output logic                  udr,
  input  logic                  flag_clr
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CH_W:0] NUM_CH_L = NUM_CH[CH_W:0];

  logic [CH_W+DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] entries_q, entries_d;
  logic             empty_q, empty_d, full_q, full_d, wm_hit_q, wm_hit_d;
  logic             ovr_q, ovr_d, udr_q, udr_d, rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [CH_W-1:0]  rd_ch_q;
  logic             wr_ok, rd_ok, mem_we, ovr_evt, udr_evt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ok      = wr_en && ({1'b0, wr_ch} < NUM_CH_L);
    rd_ok      = !flush && rd_en && (entries_q != '0);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    entries_d  = entries_q;
    mem_we     = 1'b0;
    ovr_evt    = 1'b0;
    udr_evt    = 1'b0;
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      entries_d = '0;
    end else begin
      udr_evt = rd_en && (entries_q == '0);
      if (wr_ok) begin
        if (rd_ok || !full_q) begin
          mem_we   = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
          ovr_evt = 1'b1;
          // Overwrite mode: the oldest slot is the write slot, so both pointers step.
          if (OVR_MODE != 0) begin
            mem_we   = 1'b1;
            wr_ptr_d = ptr_inc(wr_ptr_q);
            rd_ptr_d = ptr_inc(rd_ptr_q);
          end
        end
      end
      if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (rd_ok && !wr_ok)
        entries_d = entries_q - CNT_W'(1);
      else if (wr_ok && !rd_ok && !full_q)
        entries_d = entries_q + CNT_W'(1);
    end
    empty_d    = (entries_d == '0);
    full_d     = (entries_d == CNT_W'(DEPTH));
    wm_hit_d   = (wm_level != '0) && (entries_d >= wm_level);
    rd_valid_d = rd_ok;
    // A flagged event in the same cycle as flag_clr keeps the flag set.
    ovr_d      = ovr_evt ? 1'b1 : (flag_clr ? 1'b0 : ovr_q);
    udr_d      = udr_evt ? 1'b1 : (flag_clr ? 1'b0 : udr_q);
  end

  always_ff @(posedge mems_clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      entries_q  <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      wm_hit_q   <= 1'b0;
      ovr_q      <= 1'b0;
      udr_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      entries_q  <= entries_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      wm_hit_q   <= wm_hit_d;
      ovr_q      <= ovr_d;
      udr_q      <= udr_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge mems_clk) begin
    if (!rst && mem_we) mem[wr_ptr_q] <= {wr_ch, wr_data};
  end

  // Registered read port; old data is returned when a full FIFO reads and writes one slot.
  always_ff @(posedge mems_clk) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_ch_q   <= '0;
    end else if (rd_ok) begin
      {rd_ch_q, rd_data_q} <= mem[rd_ptr_q];
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_ch    = rd_ch_q;
  assign entries  = entries_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign wm_hit   = wm_hit_q;
  assign ovr      = ovr_q;
  assign udr      = udr_q;

endmodule
